// File: rtl/md5_stream_core.sv
// Iterative MD5 compression engine: UNROLL steps per clock, A/B/C/D chained across message blocks.
// Define MD5_DEBUG_EN to expose the working registers, step counter and round constant on debug ports.
module md5_stream_core #(
    parameter int UNROLL = 1,
    parameter int WORD_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    blk_valid_i,
    output logic                    blk_ready_o,
    input  logic                    blk_first_i,
    input  logic                    blk_last_i,
    input  logic [15:0][WORD_W-1:0] M_i,
    output logic                    hash_valid_o,
    input  logic                    hash_ready_i,
    output logic [4*WORD_W-1:0]     hash_o,
    output logic                    busy_o
`ifdef MD5_DEBUG_EN
    ,
    output logic [WORD_W-1:0]       dbg_A_o,
    output logic [WORD_W-1:0]       dbg_B_o,
    output logic [WORD_W-1:0]       dbg_C_o,
    output logic [WORD_W-1:0]       dbg_D_o,
    output logic [5:0]              dbg_step_o,
    output logic [1:0]              dbg_round_o,
    output logic [WORD_W-1:0]       dbg_K_o
`endif
);

    if (WORD_W != 32) begin : g_bad_width
        $error("md5_stream_core: WORD_W must be 32");
    end
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("md5_stream_core: UNROLL must be 1, 2, 4 or 8");
    end

    typedef logic [31:0] word_t;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_HOLD} state_t;

    localparam word_t IV_A = 32'h67452301;
    localparam word_t IV_B = 32'hefcdab89;
    localparam word_t IV_C = 32'h98badcfe;
    localparam word_t IV_D = 32'h10325476;
    localparam logic [5:0] LAST_STEP = 6'(64 - UNROLL);
    localparam logic [5:0] STEP_INC  = 6'(UNROLL);

    localparam word_t K_ROM [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    function automatic word_t md5_f(input logic [1:0] rnd, input word_t b, input word_t c, input word_t d);
        case (rnd)
            2'd0:    return (b & c) | (~b & d);
            2'd1:    return (d & b) | (~d & c);
            2'd2:    return b ^ c ^ d;
            default: return c ^ (b | ~d);
        endcase
    endfunction

    // Index arithmetic is done mod 16 directly, since 16 divides each round's base step times its multiplier.
    function automatic logic [3:0] md5_idx(input logic [5:0] g);
        case (g[5:4])
            2'd0:    return g[3:0];
            2'd1:    return g[3:0] * 4'd5 + 4'd1;
            2'd2:    return g[3:0] * 4'd3 + 4'd5;
            default: return g[3:0] * 4'd7;
        endcase
    endfunction

    function automatic logic [4:0] md5_s(input logic [5:0] g);
        case ({g[5:4], g[1:0]})
            4'h0: return 5'd7;   4'h1: return 5'd12;  4'h2: return 5'd17;  4'h3: return 5'd22;
            4'h4: return 5'd5;   4'h5: return 5'd9;   4'h6: return 5'd14;  4'h7: return 5'd20;
            4'h8: return 5'd4;   4'h9: return 5'd11;  4'ha: return 5'd16;  4'hb: return 5'd23;
            4'hc: return 5'd6;   4'hd: return 5'd10;  4'he: return 5'd15;  default: return 5'd21;
        endcase
    endfunction

    function automatic word_t rotl(input word_t x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic word_t bswap(input word_t x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    state_t                    state_q, state_d;
    logic [15:0][WORD_W-1:0]   msg_q;
    logic                      first_q, last_q;
    word_t                     a_q, b_q, c_q, d_q;
    word_t                     a_d, b_d, c_d, d_d;
    word_t                     ca_q, cb_q, cc_q, cd_q;
    word_t                     sa, sb, sc, sd;
    logic [5:0]                step_q;
    logic [127:0]              hash_q;
    logic [5:0]                g;
    word_t                     t, nb;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (blk_valid_i) state_d = S_LOAD;
            S_LOAD:  state_d = S_ROUND;
            S_ROUND: if (step_q == LAST_STEP) state_d = S_FINAL;
            S_FINAL: state_d = last_q ? S_HOLD : S_IDLE;
            S_HOLD:  if (hash_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        blk_ready_o  = (state_q == S_IDLE);
        hash_valid_o = (state_q == S_HOLD);
        busy_o       = (state_q != S_IDLE);
    end

    // UNROLL chained MD5 steps evaluated combinationally from the current working registers.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        g   = step_q;
        t   = '0;
        nb  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            g   = step_q + 6'(i);
            t   = a_d + md5_f(g[5:4], b_d, c_d, d_d) + K_ROM[g] + msg_q[md5_idx(g)];
            nb  = b_d + rotl(t, md5_s(g));
            a_d = d_d;
            d_d = c_d;
            c_d = b_d;
            b_d = nb;
        end
    end

    assign sa = ca_q + a_q;
    assign sb = cb_q + b_q;
    assign sc = cc_q + c_q;
    assign sd = cd_q + d_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            msg_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            a_q <= IV_A;  b_q <= IV_B;  c_q <= IV_C;  d_q <= IV_D;
            ca_q <= IV_A; cb_q <= IV_B; cc_q <= IV_C; cd_q <= IV_D;
            step_q  <= '0;
            hash_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (blk_valid_i) begin
                        msg_q   <= M_i;
                        first_q <= blk_first_i;
                        last_q  <= blk_last_i;
                    end
                end
                S_LOAD: begin
                    step_q <= '0;
                    if (first_q) begin
                        a_q <= IV_A;  b_q <= IV_B;  c_q <= IV_C;  d_q <= IV_D;
                        ca_q <= IV_A; cb_q <= IV_B; cc_q <= IV_C; cd_q <= IV_D;
                    end else begin
                        a_q <= ca_q;  b_q <= cb_q;  c_q <= cc_q;  d_q <= cd_q;
                    end
                end
                S_ROUND: begin
                    a_q <= a_d;  b_q <= b_d;  c_q <= c_d;  d_q <= d_d;
                    step_q <= step_q + STEP_INC;
                end
                S_FINAL: begin
                    ca_q <= sa;  cb_q <= sb;  cc_q <= sc;  cd_q <= sd;
                    if (last_q) hash_q <= {bswap(sa), bswap(sb), bswap(sc), bswap(sd)};
                end
                default: ;
            endcase
        end
    end

    assign hash_o = hash_q;

`ifdef MD5_DEBUG_EN
    assign dbg_A_o     = a_q;
    assign dbg_B_o     = b_q;
    assign dbg_C_o     = c_q;
    assign dbg_D_o     = d_q;
    assign dbg_step_o  = step_q;
    assign dbg_round_o = step_q[5:4];
    assign dbg_K_o     = (state_q == S_ROUND) ? K_ROM[step_q] : '0;
`endif

endmodule

// File: tb/tb_md5_stream_core.sv
// Directed bench for md5_stream_core: known MD5 digests, latency, back-pressure and reset behaviour.
// Two instances: UNROLL=4 for most scenarios, UNROLL=1 for the single-step empty-message case.
module tb_md5_stream_core;

    localparam int LAT4 = 64 / 4 + 2;
    localparam int LAT1 = 64 / 1 + 2;
    localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] D_TWO   = 128'h8215ef0796a20bcaaae116d3876c664a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst = 1'b1;
    logic                valid = 1'b0, first = 1'b0, last = 1'b0, hready = 1'b0;
    logic                valid1 = 1'b0, hready1 = 1'b0;
    logic [15:0][31:0]   M = '0;
    logic                ready, hvalid, busy, ready1, hvalid1, busy1;
    logic [127:0]        hash, hash1;

    logic [15:0][31:0]   wEmpty, wAbc, wTwo1, wTwo2;
    int                  checks = 0, errors = 0;
    int                  lat;
    logic                saw;

    md5_stream_core #(.UNROLL(4), .WORD_W(32)) dut4 (
        .clk_i(clk), .rst_i(rst), .blk_valid_i(valid), .blk_ready_o(ready),
        .blk_first_i(first), .blk_last_i(last), .M_i(M),
        .hash_valid_o(hvalid), .hash_ready_i(hready), .hash_o(hash), .busy_o(busy)
    );

    md5_stream_core #(.UNROLL(1), .WORD_W(32)) dut1 (
        .clk_i(clk), .rst_i(rst), .blk_valid_i(valid1), .blk_ready_o(ready1),
        .blk_first_i(first), .blk_last_i(last), .M_i(M),
        .hash_valid_o(hvalid1), .hash_ready_i(hready1), .hash_o(hash1), .busy_o(busy1)
    );

    // Offers one block to dut4 from IDLE and counts cycles until the digest (last) or ready (not last).
    task automatic send_block(input logic [15:0][31:0] w, input logic f, input logic l,
                              output int cyc, output logic sawHv);
        M = w; first = f; last = l; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        cyc = -1;
        sawHv = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (hvalid) sawHv = 1'b1;
            if ((l && hvalid) || (!l && ready)) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic ack_digest;
        hready = 1'b1;
        @(posedge clk); #1;
        hready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
        checks++; if (hvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_hvalid got %b want 0", hvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (hash !== 128'h0) begin errors++; $display("[TB] FAIL reset_hash got %h want 0", hash); end
        checks++; if (ready1 !== 1'b1 || busy1 !== 1'b0 || hash1 !== 128'h0) begin
            errors++; $display("[TB] FAIL reset_u1 got ready=%b busy=%b hash=%h want 1 0 0", ready1, busy1, hash1);
        end
    endtask

    task automatic test_empty_u1;
        int c1;
        M = wEmpty; first = 1'b1; last = 1'b1; valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        c1 = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (hvalid1) begin c1 = c; break; end
        end
        checks++; if (c1 != LAT1) begin errors++; $display("[TB] FAIL u1_latency got %0d want %0d", c1, LAT1); end
        checks++; if (hash1 !== D_EMPTY) begin errors++; $display("[TB] FAIL u1_empty_hash got %h want %h", hash1, D_EMPTY); end
        hready1 = 1'b1;
        @(posedge clk); #1;
        hready1 = 1'b0;
        checks++; if (hvalid1 !== 1'b0 || ready1 !== 1'b1) begin
            errors++; $display("[TB] FAIL u1_release got hvalid=%b ready=%b want 0 1", hvalid1, ready1);
        end
    endtask

    task automatic test_abc_backpressure;
        send_block(wAbc, 1'b1, 1'b1, lat, saw);
        checks++; if (lat != LAT4) begin errors++; $display("[TB] FAIL abc_latency got %0d want %0d", lat, LAT4); end
        checks++; if (hash !== D_ABC) begin errors++; $display("[TB] FAIL abc_hash got %h want %h", hash, D_ABC); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL hold_busy got %b want 1", busy); end
        M = wEmpty; first = 1'b1; last = 1'b1; valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (hvalid !== 1'b1 || ready !== 1'b0 || hash !== D_ABC) begin
                errors++;
                $display("[TB] FAIL hold_stable cyc %0d got hvalid=%b ready=%b hash=%h want 1 0 %h",
                         c, hvalid, ready, hash, D_ABC);
            end
        end
        valid = 1'b0;
        ack_digest();
        checks++; if (hvalid !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL release got hvalid=%b ready=%b busy=%b want 0 1 0", hvalid, ready, busy);
        end
        checks++; if (hash !== D_ABC) begin errors++; $display("[TB] FAIL hash_kept got %h want %h", hash, D_ABC); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignored_block got busy=%b want 0", busy); end
    endtask

    task automatic test_two_block;
        send_block(wTwo1, 1'b1, 1'b0, lat, saw);
        checks++; if (lat != LAT4) begin errors++; $display("[TB] FAIL blk1_ready_latency got %0d want %0d", lat, LAT4); end
        checks++; if (saw !== 1'b0 || hvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL blk1_no_digest got saw=%b hvalid=%b want 0 0", saw, hvalid);
        end
        send_block(wTwo2, 1'b0, 1'b1, lat, saw);
        checks++; if (lat != LAT4) begin errors++; $display("[TB] FAIL blk2_latency got %0d want %0d", lat, LAT4); end
        checks++; if (hash !== D_TWO) begin errors++; $display("[TB] FAIL two_block_hash got %h want %h", hash, D_TWO); end
        ack_digest();
    endtask

    task automatic test_back_to_back;
        send_block(wTwo1, 1'b1, 1'b0, lat, saw);
        checks++; if (lat != LAT4) begin errors++; $display("[TB] FAIL b2b_prefix_latency got %0d want %0d", lat, LAT4); end
        send_block(wAbc, 1'b1, 1'b1, lat, saw);
        checks++; if (hash !== D_ABC) begin errors++; $display("[TB] FAIL b2b_abc_hash got %h want %h", hash, D_ABC); end
        ack_digest();
        send_block(wEmpty, 1'b1, 1'b1, lat, saw);
        checks++; if (lat != LAT4) begin errors++; $display("[TB] FAIL b2b_empty_latency got %0d want %0d", lat, LAT4); end
        checks++; if (hash !== D_EMPTY) begin errors++; $display("[TB] FAIL b2b_empty_hash got %h want %h", hash, D_EMPTY); end
        ack_digest();
    endtask

    task automatic test_reset_mid_round;
        send_block(wTwo1, 1'b1, 1'b0, lat, saw);
        M = wAbc; first = 1'b0; last = 1'b1; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || hvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_round got busy=%b hvalid=%b want 1 0", busy, hvalid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || hvalid !== 1'b0 || hash !== 128'h0) begin
            errors++; $display("[TB] FAIL abort_reset got ready=%b busy=%b hvalid=%b hash=%h want 1 0 0 0",
                               ready, busy, hvalid, hash);
        end
        send_block(wEmpty, 1'b0, 1'b1, lat, saw);
        checks++; if (lat != LAT4) begin errors++; $display("[TB] FAIL after_abort_latency got %0d want %0d", lat, LAT4); end
        checks++; if (hash !== D_EMPTY) begin errors++; $display("[TB] FAIL after_abort_hash got %h want %h", hash, D_EMPTY); end
        ack_digest();
    endtask

    initial begin
        wEmpty = '0;
        wEmpty[0] = 32'h00000080;
        wAbc = '0;
        wAbc[0] = 32'h80636261;
        wAbc[14] = 32'h00000018;
        wTwo1 = '0;
        wTwo1[0]  = 32'h64636261; wTwo1[1]  = 32'h65646362; wTwo1[2]  = 32'h66656463;
        wTwo1[3]  = 32'h67666564; wTwo1[4]  = 32'h68676665; wTwo1[5]  = 32'h69686766;
        wTwo1[6]  = 32'h6a696867; wTwo1[7]  = 32'h6b6a6968; wTwo1[8]  = 32'h6c6b6a69;
        wTwo1[9]  = 32'h6d6c6b6a; wTwo1[10] = 32'h6e6d6c6b; wTwo1[11] = 32'h6f6e6d6c;
        wTwo1[12] = 32'h706f6e6d; wTwo1[13] = 32'h71706f6e; wTwo1[14] = 32'h00000080;
        wTwo2 = '0;
        wTwo2[14] = 32'h000001c0;

        test_reset();
        test_empty_u1();
        test_abc_backpressure();
        test_two_block();
        test_back_to_back();
        test_reset_mid_round();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
